// File: rtl/hpdcache_victim_req_ctrl.sv
// ---------------------------------------------------------------------------
// hpdcache_victim_req_ctrl
//
// Purpose: serves refill victim requests. For an accepted set it reads the
// directory, hands the per-way state to an external victim selector, marks
// the chosen way as fetching and returns {set, one-hot way, evict} on a
// valid/ready response port. When every way of the set is already being
// fetched it parks in WAIT_CLR until some refill completes, then re-reads
// the directory.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_*                  victim request (valid/ready), target set
//   dir_rd_o/dir_rd_set_o  directory read strobe and set
//   dir_*_i                per-way directory state, one cycle after dir_rd_o
//   sel_*                  victim selector strobe, set, per-way state, result
//   dir_fetch_set_o/_way_o pulse that marks the chosen way as fetching
//   fetch_clr_i            some in-flight refill has completed
//   rsp_*                  victim response (valid/ready): set, way, evict
//   retry_cnt_o            saturating count of no-victim retries
//   dbg_state              current FSM state (IDLE=0 DIR_WAIT=1 RSP=2 WAIT_CLR=3)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Once rsp_valid_o is raised it stays high with a stable payload
// until that transfer; req_ready_o only depends on the FSM state.
// ---------------------------------------------------------------------------
package hpdcache_pkg;
   typedef struct packed {
      int unsigned sets;
      int unsigned ways;
   } hpdcache_user_cfg_t;

   typedef struct packed {
      hpdcache_user_cfg_t u;
   } hpdcache_cfg_t;
endpackage

module hpdcache_victim_req_ctrl
   import hpdcache_pkg::*;
#(
   parameter hpdcache_cfg_t HPDcacheCfg = '0,
   // An all-zero configuration still elaborates to a 2-set, 1-way block.
   localparam int unsigned SETS  = (HPDcacheCfg.u.sets < 2) ? 2 : HPDcacheCfg.u.sets,
   localparam int unsigned WAYS  = (HPDcacheCfg.u.ways < 1) ? 1 : HPDcacheCfg.u.ways,
   localparam int unsigned SET_W = $clog2(SETS)
) (
   input  logic              clk_i,
   input  logic              rst_ni,

   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [SET_W-1:0]  req_set_i,

   output logic              dir_rd_o,
   output logic [SET_W-1:0]  dir_rd_set_o,
   input  logic [WAYS-1:0]   dir_valid_i,
   input  logic [WAYS-1:0]   dir_wback_i,
   input  logic [WAYS-1:0]   dir_dirty_i,
   input  logic [WAYS-1:0]   dir_fetch_i,

   output logic              sel_victim_o,
   output logic [SET_W-1:0]  sel_set_o,
   output logic [WAYS-1:0]   sel_dir_valid_o,
   output logic [WAYS-1:0]   sel_dir_wback_o,
   output logic [WAYS-1:0]   sel_dir_dirty_o,
   output logic [WAYS-1:0]   sel_dir_fetch_o,
   input  logic [WAYS-1:0]   sel_victim_way_i,

   output logic              dir_fetch_set_o,
   output logic [WAYS-1:0]   dir_fetch_way_o,
   input  logic              fetch_clr_i,

   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [SET_W-1:0]  rsp_set_o,
   output logic [WAYS-1:0]   rsp_way_o,
   output logic              rsp_evict_o,

   output logic [7:0]        retry_cnt_o,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIR_WAIT = 2'd1,
      RSP      = 2'd2,
      WAIT_CLR = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [SET_W-1:0]   set_q;
   logic [WAYS-1:0]    way_q;
   logic               evict_q;
   logic [7:0]         retry_q;

   logic               victim_found;

   assign victim_found = (sel_victim_way_i != '0);

   // Directory state goes straight to the selector; it is only meaningful
   // while sel_victim_o is high.
   assign sel_set_o       = set_q;
   assign sel_dir_valid_o = dir_valid_i;
   assign sel_dir_wback_o = dir_wback_i;
   assign sel_dir_dirty_o = dir_dirty_i;
   assign sel_dir_fetch_o = dir_fetch_i;

   assign rsp_set_o   = set_q;
   assign rsp_way_o   = way_q;
   assign rsp_evict_o = evict_q;
   assign retry_cnt_o = retry_q;
   assign dbg_state   = state_q;

   always_comb begin
      state_d         = state_q;
      req_ready_o     = 1'b0;
      dir_rd_o        = 1'b0;
      dir_rd_set_o    = set_q;
      sel_victim_o    = 1'b0;
      dir_fetch_set_o = 1'b0;
      dir_fetch_way_o = '0;
      rsp_valid_o     = 1'b0;

      unique case (state_q)
         IDLE: begin
            req_ready_o  = 1'b1;
            // The incoming set goes to the directory in the accept cycle,
            // before it is registered.
            dir_rd_set_o = req_set_i;
            if (req_valid_i) begin
               dir_rd_o = 1'b1;
               state_d  = DIR_WAIT;
            end
         end
         DIR_WAIT: begin
            sel_victim_o = 1'b1;
            if (victim_found) begin
               dir_fetch_set_o = 1'b1;
               dir_fetch_way_o = sel_victim_way_i;
               state_d         = RSP;
            end else begin
               state_d = WAIT_CLR;
            end
         end
         RSP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) state_d = IDLE;
         end
         WAIT_CLR: begin
            // fetch_clr_i is only sampled here, so a completion coinciding
            // with the move into this state is not seen.
            if (fetch_clr_i) begin
               dir_rd_o = 1'b1;
               state_d  = DIR_WAIT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         set_q   <= '0;
         way_q   <= '0;
         evict_q <= 1'b0;
         retry_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req_valid_i) set_q <= req_set_i;
         if (state_q == DIR_WAIT) begin
            if (victim_found) begin
               way_q   <= sel_victim_way_i;
               evict_q <= |(sel_victim_way_i & dir_valid_i & dir_dirty_i);
            end else if (retry_q != 8'hff) begin
               retry_q <= retry_q + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hpdcache_victim_req_ctrl.sv
// ---------------------------------------------------------------------------
// Directed bench for hpdcache_victim_req_ctrl (16 sets, 4 ways).
// Inputs change right after a falling edge; outputs are checked 1 ns later,
// away from the rising edge the DUT uses.
// ---------------------------------------------------------------------------
module tb_hpdcache_victim_req_ctrl;
   import hpdcache_pkg::*;

   localparam hpdcache_cfg_t CFG = '{u: '{sets: 32'd16, ways: 32'd4}};
   localparam logic [1:0] S_IDLE = 2'd0, S_DIR_WAIT = 2'd1, S_RSP = 2'd2, S_WAIT_CLR = 2'd3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid, req_ready;
   logic [3:0] req_set;
   logic       dir_rd;
   logic [3:0] dir_rd_set;
   logic [3:0] dir_valid, dir_wback, dir_dirty, dir_fetch;
   logic       sel_victim;
   logic [3:0] sel_set;
   logic [3:0] sel_dir_valid, sel_dir_wback, sel_dir_dirty, sel_dir_fetch;
   logic [3:0] sel_way;
   logic       fetch_set;
   logic [3:0] fetch_way;
   logic       fetch_clr;
   logic       rsp_valid, rsp_ready;
   logic [3:0] rsp_set, rsp_way;
   logic       rsp_evict;
   logic [7:0] retry_cnt;
   logic [1:0] state;

   int n_cmp = 0;
   int n_err = 0;

   hpdcache_victim_req_ctrl #(.HPDcacheCfg(CFG)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_set_i(req_set),
      .dir_rd_o(dir_rd), .dir_rd_set_o(dir_rd_set),
      .dir_valid_i(dir_valid), .dir_wback_i(dir_wback),
      .dir_dirty_i(dir_dirty), .dir_fetch_i(dir_fetch),
      .sel_victim_o(sel_victim), .sel_set_o(sel_set),
      .sel_dir_valid_o(sel_dir_valid), .sel_dir_wback_o(sel_dir_wback),
      .sel_dir_dirty_o(sel_dir_dirty), .sel_dir_fetch_o(sel_dir_fetch),
      .sel_victim_way_i(sel_way),
      .dir_fetch_set_o(fetch_set), .dir_fetch_way_o(fetch_way), .fetch_clr_i(fetch_clr),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_set_o(rsp_set),
      .rsp_way_o(rsp_way), .rsp_evict_o(rsp_evict),
      .retry_cnt_o(retry_cnt), .dbg_state(state)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog: every wait below is a fixed number of cycles, this is a backstop
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_set = '0;
      dir_valid = '0; dir_wback = '0; dir_dirty = '0; dir_fetch = '0;
      sel_way = '0; fetch_clr = 1'b0; rsp_ready = 1'b0;
      next_cycle(); next_cycle();
      #1;
      // ---- reset state
      chk("rst_req_ready", 32'(req_ready), 1);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_dir_rd", 32'(dir_rd), 0);
      chk("rst_sel_victim", 32'(sel_victim), 0);
      chk("rst_fetch_set", 32'(fetch_set), 0);
      chk("rst_retry", 32'(retry_cnt), 0);
      chk("rst_state", 32'(state), 32'(S_IDLE));
      next_cycle();
      rst_n = 1'b1;

      // ---- clean victim, set 5, way 0100
      next_cycle();
      req_valid = 1'b1; req_set = 4'd5; rsp_ready = 1'b1;
      #1;
      chk("hit_dir_rd", 32'(dir_rd), 1);
      chk("hit_dir_rd_set", 32'(dir_rd_set), 5);
      chk("hit_req_ready", 32'(req_ready), 1);
      next_cycle();   // N+1
      req_valid = 1'b0; req_set = 4'd9;
      dir_valid = 4'b1111; dir_dirty = 4'b0000; dir_fetch = 4'b0000; dir_wback = 4'b1010;
      sel_way = 4'b0100;
      #1;
      chk("hit_sel_victim", 32'(sel_victim), 1);
      chk("hit_sel_set", 32'(sel_set), 5);
      chk("hit_sel_dir_valid", 32'(sel_dir_valid), 32'hf);
      chk("hit_sel_dir_wback", 32'(sel_dir_wback), 32'ha);
      chk("hit_fetch_set", 32'(fetch_set), 1);
      chk("hit_fetch_way", 32'(fetch_way), 32'h4);
      chk("hit_req_ready_busy", 32'(req_ready), 0);
      chk("hit_dir_rd_busy", 32'(dir_rd), 0);
      next_cycle();   // N+2
      #1;
      chk("hit_rsp_valid", 32'(rsp_valid), 1);
      chk("hit_rsp_set", 32'(rsp_set), 5);
      chk("hit_rsp_way", 32'(rsp_way), 32'h4);
      chk("hit_rsp_evict", 32'(rsp_evict), 0);
      chk("hit_fetch_set_off", 32'(fetch_set), 0);
      chk("hit_fetch_way_off", 32'(fetch_way), 0);
      chk("hit_sel_victim_off", 32'(sel_victim), 0);
      next_cycle();   // N+3
      #1;
      chk("hit_back_idle", 32'(state), 32'(S_IDLE));
      chk("hit_rsp_valid_off", 32'(rsp_valid), 0);
      chk("hit_req_ready_again", 32'(req_ready), 1);

      // ---- dirty victim with 5 cycles of backpressure, set 2, way 0001
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_set = 4'd2;
      next_cycle();
      req_valid = 1'b0;
      dir_valid = 4'b1111; dir_dirty = 4'b0001; dir_fetch = 4'b0000;
      sel_way = 4'b0001;
      #1;
      chk("dirty_fetch_way", 32'(fetch_way), 32'h1);
      next_cycle();
      sel_way = 4'b0000; dir_dirty = 4'b0000;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            req_valid = 1'b1; req_set = 4'd7;
         end else begin
            req_valid = 1'b0;
         end
         #1;
         chk("bp_rsp_valid", 32'(rsp_valid), 1);
         chk("bp_rsp_set", 32'(rsp_set), 2);
         chk("bp_rsp_way", 32'(rsp_way), 32'h1);
         chk("bp_rsp_evict", 32'(rsp_evict), 1);
         chk("bp_req_ready", 32'(req_ready), 0);
         chk("bp_dir_rd", 32'(dir_rd), 0);
         next_cycle();
      end
      req_valid = 1'b0;
      #1;
      chk("bp_still_rsp", 32'(state), 32'(S_RSP));
      rsp_ready = 1'b1;
      next_cycle();
      #1;
      chk("bp_idle", 32'(state), 32'(S_IDLE));
      chk("bp_rsp_valid_off", 32'(rsp_valid), 0);

      // ---- all ways fetching, set 3
      req_valid = 1'b1; req_set = 4'd3;
      next_cycle();   // DIR_WAIT
      req_valid = 1'b0;
      dir_fetch = 4'b1111; sel_way = 4'b0000;
      fetch_clr = 1'b1;   // coincides with the move into WAIT_CLR: must be missed
      #1;
      chk("full_sel_victim", 32'(sel_victim), 1);
      chk("full_no_fetch_mark", 32'(fetch_set), 0);
      chk("full_fetch_way_zero", 32'(fetch_way), 0);
      next_cycle();   // WAIT_CLR
      fetch_clr = 1'b0;
      #1;
      chk("full_state_wait", 32'(state), 32'(S_WAIT_CLR));
      chk("full_retry", 32'(retry_cnt), 1);
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         #1;
         chk("full_holding", 32'(state), 32'(S_WAIT_CLR));
         chk("full_no_rd", 32'(dir_rd), 0);
      end
      fetch_clr = 1'b1;
      #1;
      chk("full_reissue_rd", 32'(dir_rd), 1);
      chk("full_reissue_set", 32'(dir_rd_set), 3);
      next_cycle();   // DIR_WAIT again
      fetch_clr = 1'b0;
      dir_fetch = 4'b1011; sel_way = 4'b0100; dir_dirty = 4'b0100;
      dir_valid = 4'b1011;   // victim way not valid: no writeback despite dirty
      #1;
      chk("full_fetch_mark", 32'(fetch_set), 1);
      chk("full_fetch_mark_way", 32'(fetch_way), 32'h4);
      next_cycle();   // RSP
      #1;
      chk("full_rsp_valid", 32'(rsp_valid), 1);
      chk("full_rsp_set", 32'(rsp_set), 3);
      chk("full_rsp_way", 32'(rsp_way), 32'h4);
      chk("full_rsp_evict", 32'(rsp_evict), 0);
      next_cycle();
      #1;
      chk("full_idle", 32'(state), 32'(S_IDLE));
      chk("full_retry_kept", 32'(retry_cnt), 1);

      // ---- reset while in DIR_WAIT
      dir_valid = 4'b1111; dir_dirty = 4'b0000; dir_fetch = 4'b0000;
      req_valid = 1'b1; req_set = 4'd6;
      next_cycle();   // DIR_WAIT
      req_valid = 1'b0; sel_way = 4'b0010;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_state", 32'(state), 32'(S_IDLE));
      chk("mid_rst_req_ready", 32'(req_ready), 1);
      chk("mid_rst_fetch_set", 32'(fetch_set), 0);
      chk("mid_rst_retry", 32'(retry_cnt), 0);
      next_cycle();
      #1;
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
      chk("mid_rst_sel_victim", 32'(sel_victim), 0);
      rst_n = 1'b1;
      next_cycle();
      #1;
      chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
      chk("post_rst_fetch_set", 32'(fetch_set), 0);
      chk("post_rst_state", 32'(state), 32'(S_IDLE));

      // ---- retry counter saturation: 260 consecutive no-victim passes
      req_valid = 1'b1; req_set = 4'd1;
      next_cycle();   // DIR_WAIT
      req_valid = 1'b0; sel_way = 4'b0000; dir_fetch = 4'b1111; fetch_clr = 1'b1;
      for (int k = 1; k <= 260; k++) begin
         next_cycle();   // WAIT_CLR, k retries so far
         #1;
         if (k == 254) chk("sat_254", 32'(retry_cnt), 254);
         if (k == 255) chk("sat_255", 32'(retry_cnt), 255);
         if (k == 260) begin
            chk("sat_260", 32'(retry_cnt), 255);
            chk("sat_state", 32'(state), 32'(S_WAIT_CLR));
         end
         if (k != 260) next_cycle();   // back to DIR_WAIT
      end
      sel_way = 4'b1000; dir_fetch = 4'b0111;
      next_cycle();   // DIR_WAIT
      fetch_clr = 1'b0;
      #1;
      chk("sat_exit_fetch_set", 32'(fetch_set), 1);
      next_cycle();   // RSP
      #1;
      chk("sat_exit_rsp_way", 32'(rsp_way), 32'h8);
      chk("sat_exit_rsp_set", 32'(rsp_set), 1);
      next_cycle();   // IDLE
      #1;
      chk("sat_exit_idle", 32'(state), 32'(S_IDLE));
      chk("sat_hold", 32'(retry_cnt), 255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hpdcache_victim_req_ctrl.md
HPDCACHE_VICTIM_REQ_CTRL -- requirements
Module: hpdcache_victim_req_ctrl

Interface
REQ-001 The block SHALL take parameter HPDcacheCfg (hpdcache_cfg_t, default '0): cache configuration; set_t = logic[$clog2(HPDcacheCfg.u.sets)-1:0], way_vector_t = logic[HPDcacheCfg.u.ways-1:0].
REQ-002 The block SHALL have one clock and an asynchronous active-low reset: clk_i input 1, clock; rst_ni input 1, async active-low reset.
REQ-003 The request ports SHALL be: req_valid_i input 1, refill victim request; req_ready_o output 1, request accepted; req_set_i input set_t, target set.
REQ-004 The directory read ports SHALL be: dir_rd_o output 1, directory read strobe; dir_rd_set_o output set_t, set to read; dir_valid_i, dir_wback_i, dir_dirty_i, dir_fetch_i input way_vector_t, per-way state, valid exactly 1 cycle after dir_rd_o.
REQ-005 The victim selector ports SHALL be: sel_victim_o output 1, select strobe; sel_set_o output set_t; sel_dir_valid_o, sel_dir_wback_o, sel_dir_dirty_o, sel_dir_fetch_o output way_vector_t; sel_victim_way_i input way_vector_t, combinational one-hot victim or zero.
REQ-006 The fetch-marking ports SHALL be: dir_fetch_set_o output 1, set fetch bit; dir_fetch_way_o output way_vector_t; fetch_clr_i input 1, any in-flight refill has completed.
REQ-007 The response ports SHALL be: rsp_valid_o output 1; rsp_ready_i input 1; rsp_set_o output set_t; rsp_way_o output way_vector_t, one-hot victim; rsp_evict_o output 1, victim is valid and dirty (writeback needed).
REQ-008 The block SHALL provide retry_cnt_o output 8, saturating count of no-victim retries.

Function
REQ-009 The FSM SHALL have states IDLE, DIR_WAIT, RSP, WAIT_CLR.
REQ-010 In IDLE, req_ready_o SHALL be 1; in every other state it SHALL be 0.
REQ-011 In IDLE, when req_valid_i=1: dir_rd_o=1 and dir_rd_set_o=req_set_i in the same cycle, set registered, next state DIR_WAIT.
REQ-012 In DIR_WAIT: sel_victim_o=1; sel_set_o is the registered set; sel_dir_*_o are wired directly from dir_*_i.
REQ-013 In DIR_WAIT with sel_victim_way_i nonzero: register the way; set rsp_evict_o = |(way & dir_valid_i & dir_dirty_i); pulse dir_fetch_set_o=1 with dir_fetch_way_o=way for exactly that cycle; next state RSP.
REQ-014 In DIR_WAIT with sel_victim_way_i zero (all ways fetching): next state WAIT_CLR; retry_cnt_o increments, saturating at 255.
REQ-015 In WAIT_CLR, when fetch_clr_i=1: dir_rd_o=1 with dir_rd_set_o=registered set in that cycle; next state DIR_WAIT. Otherwise remain.
REQ-016 In RSP, rsp_valid_o SHALL be 1 and rsp_set_o, rsp_way_o, rsp_evict_o SHALL be held stable until rsp_ready_i=1; on that handshake, next state IDLE. The block SHALL NOT deassert rsp_valid_o before the handshake.
REQ-017 Round-trip latency SHALL be: accept in cycle N, fetch mark in N+1, rsp_valid_o in N+2 (no retry, rsp_ready_i=1) -> IDLE in N+3.
REQ-018 sel_victim_o, dir_rd_o and dir_fetch_set_o SHALL be 0 in every state and cycle not listed above; dir_fetch_way_o SHALL be 0 when dir_fetch_set_o=0.
REQ-019 req_valid_i in non-IDLE states SHALL be ignored (not captured). fetch_clr_i outside WAIT_CLR SHALL be ignored.
REQ-020 A fetch_clr_i arriving in the same cycle as the transition into WAIT_CLR SHALL NOT be seen (evaluated only while in WAIT_CLR).

Reset
REQ-021 On rst_ni=0 (any state, including mid-operation): state=IDLE, registered set/way=0, rsp_evict_o=0, retry_cnt_o=0. Outputs: rsp_valid_o=0, dir_rd_o=0, sel_victim_o=0, dir_fetch_set_o=0, req_ready_o=1.
REQ-022 A request in flight at reset SHALL be dropped; no fetch mark or response SHALL be emitted for it.

Verification
REQ-023 Clean hit path: 4 ways, set=5, dir_valid=4'b1111, dirty=0, fetch=0, selector returns 4'b0100 -> dir_fetch_set_o pulse with way 4'b0100 at N+1; rsp_valid_o at N+2 with set 5, way 4'b0100, rsp_evict_o=0.
REQ-024 Dirty victim: selector returns 4'b0001, dir_dirty_i=4'b0001, valid=4'b1111 -> rsp_evict_o=1.
REQ-025 All fetching: dir_fetch_i=4'b1111, selector returns 0 -> WAIT_CLR, retry_cnt_o=1, no fetch mark; fetch_clr_i after 3 cycles -> dir_rd_o re-issued, then normal response.
REQ-026 Backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o and payload stable; req_ready_o=0 throughout; a req_valid_i pulse during that time is not captured.
REQ-027 Reset mid-operation: assert rst_ni=0 in DIR_WAIT -> next cycle req_ready_o=1, rsp_valid_o=0, no dir_fetch_set_o pulse.
REQ-028 Saturation: force 260 consecutive retries -> retry_cnt_o holds at 255.
